// File: rtl/zapisyvatel_bankov_if.sv
// zapisyvatel_bankov_if: CPU write ports and bank write strobes of the banked write crossbar
interface zapisyvatel_bankov_if #(
  parameter int NUM_BANKS = 3,
  parameter int SIZE_BANKI = 32,
  parameter int NUM_WR_PORTS = 4,
  parameter int SHIRINA_BANKI = $clog2(SIZE_BANKI),
  parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS)
);
  logic [NUM_WR_PORTS-1:0] req_cpu;
  logic [NUM_WR_PORTS-1:0][SHIRINA_VSEH_BANOK-1:0] wa_cpu;
  logic [NUM_WR_PORTS-1:0][31:0] wd_cpu;
  logic [NUM_WR_PORTS-1:0] gnt_cpu;
  logic [NUM_WR_PORTS-1:0] err_cpu;
  logic [NUM_BANKS-1:0] we_banki;
  logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0] wa_banki;
  logic [NUM_BANKS-1:0][31:0] wd_banki;
  logic idle;
  modport master(output req_cpu, wa_cpu, wd_cpu, input gnt_cpu, err_cpu, we_banki, wa_banki, wd_banki, idle);
  modport slave(input req_cpu, wa_cpu, wd_cpu, output gnt_cpu, err_cpu, we_banki, wa_banki, wd_banki, idle);
endinterface

// File: rtl/zapisyvatel_bankov.sv
// zapisyvatel_bankov: per-port write FIFOs with per-bank round-robin arbitration into banked memory
module zapisyvatel_bankov #(
  parameter int NUM_BANKS = 3,
  parameter int SIZE_BANKI = 32,
  parameter int SHIRINA_BANKI = $clog2(SIZE_BANKI),
  parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS),
  parameter int NUM_WR_PORTS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  zapisyvatel_bankov_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int SW = $clog2(NUM_WR_PORTS);
  localparam int AW = SHIRINA_VSEH_BANOK;
  localparam int LW = SHIRINA_BANKI;
  logic [BW-1:0] r_fb [NUM_WR_PORTS][FIFO_DEPTH];
  logic [LW-1:0] r_fa [NUM_WR_PORTS][FIFO_DEPTH];
  logic [31:0] r_fd [NUM_WR_PORTS][FIFO_DEPTH];
  logic [PW:0] r_wp [NUM_WR_PORTS];
  logic [PW:0] r_rp [NUM_WR_PORTS];
  logic [SW-1:0] r_ptr [NUM_BANKS];
  logic [NUM_WR_PORTS-1:0] r_err;
  logic [NUM_BANKS-1:0] r_we;
  logic [NUM_BANKS-1:0][LW-1:0] r_wa;
  logic [NUM_BANKS-1:0][31:0] r_wd;
  logic [NUM_WR_PORTS-1:0] w_empty, w_full, w_ok, w_acc, w_push, w_pop;
  logic [AW-1:0] w_bank [NUM_WR_PORTS];
  logic [LW-1:0] w_loc [NUM_WR_PORTS];
  logic [BW-1:0] w_hb [NUM_WR_PORTS];
  logic [NUM_BANKS-1:0] w_win_v;
  logic [SW-1:0] w_win [NUM_BANKS];
  logic [SW-1:0] w_idx;
  for (genvar p = 0; p < NUM_WR_PORTS; p++) begin : g_port
    assign w_empty[p] = r_wp[p] == r_rp[p];
    assign w_full[p] = (r_wp[p][PW] != r_rp[p][PW]) && (r_wp[p][PW-1:0] == r_rp[p][PW-1:0]);
    assign w_bank[p] = AW'(bus.wa_cpu[p] / SIZE_BANKI);
    assign w_loc[p] = LW'(bus.wa_cpu[p] % SIZE_BANKI);
    assign w_ok[p] = 32'(w_bank[p]) < NUM_BANKS;
    assign w_acc[p] = bus.req_cpu[p] && !w_full[p];
    assign w_push[p] = w_acc[p] && w_ok[p];
    assign w_hb[p] = r_fb[p][r_rp[p][PW-1:0]];
  end
  assign bus.gnt_cpu = ~w_full;
  assign bus.err_cpu = r_err;
  assign bus.we_banki = r_we;
  assign bus.wa_banki = r_wa;
  assign bus.wd_banki = r_wd;
  assign bus.idle = (&w_empty) && !(|r_we);
  always_comb begin
    w_win_v = '0;
    w_pop = '0;
    w_idx = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_win[b] = '0;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        w_idx = SW'((32'(r_ptr[b]) + 32'(k)) % NUM_WR_PORTS);
        if (!w_win_v[b] && !w_empty[w_idx] && w_hb[w_idx] == BW'(b)) begin
          w_win_v[b] = 1'b1;
          w_win[b] = w_idx;
        end
      end
      if (w_win_v[b]) w_pop[w_win[b]] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
      r_we <= '0;
      r_wa <= '0;
      r_wd <= '0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        r_wp[p] <= '0;
        r_rp[p] <= '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
    end else begin
      r_err <= w_acc & ~w_ok;
      r_we <= w_win_v;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (w_push[p]) begin
          r_fb[p][r_wp[p][PW-1:0]] <= BW'(w_bank[p]);
          r_fa[p][r_wp[p][PW-1:0]] <= w_loc[p];
          r_fd[p][r_wp[p][PW-1:0]] <= bus.wd_cpu[p];
          r_wp[p] <= r_wp[p] + 1'b1;
        end
        if (w_pop[p]) r_rp[p] <= r_rp[p] + 1'b1;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_win_v[b]) begin
          r_ptr[b] <= SW'((32'(w_win[b]) + 32'd1) % NUM_WR_PORTS);
          r_wa[b] <= r_fa[w_win[b]][r_rp[w_win[b]][PW-1:0]];
          r_wd[b] <= r_fd[w_win[b]][r_rp[w_win[b]][PW-1:0]];
        end
      end
    end
  end
endmodule

// File: tb/tb_zapisyvatel_bankov.sv
// tb_zapisyvatel_bankov: scoreboard bench for the banked write crossbar
module tb_zapisyvatel_bankov;
  localparam int NB = 3;
  localparam int NP = 4;
  localparam int LW = 5;
  localparam int AW = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_chk = 0;
  int n_wr = 0;
  logic saw_low;
  logic [NP-1:0] acc;
  logic [AW+31:0] dq [NP][$];
  logic [LW+31:0] exp_q [NB][$];
  always #5 clk = ~clk;
  zapisyvatel_bankov_if bus();
  zapisyvatel_bankov dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic put(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    dq[p].push_back({a, d});
  endtask
  task automatic expect_wr(input int b, input logic [LW-1:0] a, input logic [31:0] d);
    exp_q[b].push_back({a, d});
  endtask
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < NP; p++) if (acc[p]) void'(dq[p].pop_front());
    for (int p = 0; p < NP; p++) begin
      bus.req_cpu[p] = dq[p].size() > 0;
      {bus.wa_cpu[p], bus.wd_cpu[p]} = dq[p].size() > 0 ? dq[p][0] : '0;
      acc[p] = bus.req_cpu[p] && bus.gnt_cpu[p];
    end
    if (bus.gnt_cpu[0] === 1'b0) saw_low = 1'b1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bus.we_banki[b] === 1'b1) begin
        n_wr++;
        chk($sformatf("bank%0d_pending", b), 64'(exp_q[b].size() > 0), 64'd1);
        if (exp_q[b].size() > 0) chk($sformatf("bank%0d_write", b), 64'({bus.wa_banki[b], bus.wd_banki[b]}), 64'(exp_q[b].pop_front()));
      end
    end
  end
  initial begin
    logic [NB-1:0] we_seen;
    int w0;
    acc = '0;
    saw_low = 1'b0;
    bus.req_cpu = '0;
    bus.wa_cpu = '0;
    bus.wd_cpu = '0;
    do_reset();
    step();
    chk("rst_we", 64'(bus.we_banki), 64'd0);
    chk("rst_gnt", 64'(bus.gnt_cpu), 64'hF);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_err", 64'(bus.err_cpu), 64'd0);
    chk("rst_wa", 64'(bus.wa_banki), 64'd0);
    chk("rst_wd", 64'(bus.wd_banki[0] | bus.wd_banki[1] | bus.wd_banki[2]), 64'd0);
    put(0, 7'd37, 32'hDEADBEEF);
    expect_wr(1, 5'd5, 32'hDEADBEEF);
    run(3);
    chk("t1_we", 64'(bus.we_banki), 64'b010);
    chk("t1_wa", 64'(bus.wa_banki[1]), 64'd5);
    chk("t1_wd", 64'(bus.wd_banki[1]), 64'hDEADBEEF);
    step();
    chk("t1_we_off", 64'(bus.we_banki), 64'd0);
    chk("t1_idle", 64'(bus.idle), 64'd1);
    do_reset();
    put(0, 7'd1, 32'hA);
    put(1, 7'd2, 32'hB);
    put(2, 7'd3, 32'hC);
    expect_wr(0, 5'd1, 32'hA);
    expect_wr(0, 5'd2, 32'hB);
    expect_wr(0, 5'd3, 32'hC);
    run(3);
    chk("t2_c2_wa", 64'({bus.we_banki, bus.wa_banki[0]}), 64'({3'b001, 5'd1}));
    step();
    chk("t2_c3_wa", 64'({bus.we_banki, bus.wa_banki[0]}), 64'({3'b001, 5'd2}));
    step();
    chk("t2_c4_wa", 64'({bus.we_banki, bus.wa_banki[0]}), 64'({3'b001, 5'd3}));
    run(5);
    put(0, 7'd5, 32'hD);
    put(2, 7'd6, 32'hE);
    expect_wr(0, 5'd5, 32'hD);
    expect_wr(0, 5'd6, 32'hE);
    run(3);
    chk("t2_c12_wrap", 64'({bus.we_banki, bus.wa_banki[0]}), 64'({3'b001, 5'd5}));
    step();
    chk("t2_c13_wa", 64'({bus.we_banki, bus.wa_banki[0]}), 64'({3'b001, 5'd6}));
    run(2);
    do_reset();
    put(0, 7'd4, 32'h11);
    put(1, 7'd36, 32'h22);
    put(2, 7'd68, 32'h33);
    expect_wr(0, 5'd4, 32'h11);
    expect_wr(1, 5'd4, 32'h22);
    expect_wr(2, 5'd4, 32'h33);
    run(3);
    chk("t3_we", 64'(bus.we_banki), 64'b111);
    chk("t3_wa", 64'(bus.wa_banki), 64'({5'd4, 5'd4, 5'd4}));
    run(3);
    do_reset();
    saw_low = 1'b0;
    w0 = n_wr;
    for (int i = 0; i < 8; i++) begin
      put(0, AW'(64 + i), 32'(i));
      put(1, AW'(72 + i), 32'(16 + i));
    end
    for (int i = 0; i < 8; i++) begin
      expect_wr(2, LW'(i), 32'(i));
      expect_wr(2, LW'(8 + i), 32'(16 + i));
    end
    run(30);
    chk("t4_gnt0_low", 64'(saw_low), 64'd1);
    chk("t4_count", 64'(n_wr - w0), 64'd16);
    chk("t4_drain", 64'(exp_q[2].size()), 64'd0);
    do_reset();
    put(3, 7'd100, 32'h77);
    step();
    chk("t5_c0_err", 64'(bus.err_cpu), 64'd0);
    step();
    chk("t5_c1_err", 64'(bus.err_cpu), 64'b1000);
    chk("t5_c1_we", 64'(bus.we_banki), 64'd0);
    step();
    chk("t5_c2_err", 64'(bus.err_cpu), 64'd0);
    chk("t5_c2_idle", 64'(bus.idle), 64'd1);
    chk("t5_c2_we", 64'(bus.we_banki), 64'd0);
    do_reset();
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < NP; p++) put(p, AW'(32 + p * 4 + i), 32'h100 + 32'(p * 16 + i));
    expect_wr(1, 5'd0, 32'h100);
    expect_wr(1, 5'd4, 32'h110);
    run(3);
    chk("t6_c2_wd", 64'({bus.we_banki, bus.wd_banki[1]}), 64'({3'b010, 32'h100}));
    step();
    chk("t6_c3_wd", 64'({bus.we_banki, bus.wd_banki[1]}), 64'({3'b010, 32'h110}));
    rst = 1'b1;
    step();
    chk("t6_c4_we", 64'(bus.we_banki), 64'd0);
    chk("t6_c4_gnt", 64'(bus.gnt_cpu), 64'hF);
    chk("t6_c4_idle", 64'(bus.idle), 64'd1);
    chk("t6_c4_wd", 64'(bus.wd_banki[1]), 64'd0);
    rst = 1'b0;
    we_seen = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      we_seen = we_seen | bus.we_banki;
    end
    chk("t6_no_stale", 64'(we_seen), 64'd0);
    chk("leftover", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/zapisyvatel_bankov.md
Name: zapisyvatel_bankov

Overview:
- Write-side counterpart of the banked-memory read crossbar.
- Accepts 32-bit writes from NUM_WR_PORTS CPU write ports and buffers each port in its own FIFO.
- Decodes each address into a bank number and an in-bank address.
- Per-bank round-robin arbitration over the FIFO heads drives registered write strobes into the NUM_BANKS memory banks.

Parameters:
NUM_BANKS, 3, number of memory banks
SIZE_BANKI, 32, words per bank
SHIRINA_BANKI, $clog2(SIZE_BANKI), in-bank address width
SHIRINA_VSEH_BANOK, $clog2(SIZE_BANKI*NUM_BANKS), CPU address width
NUM_WR_PORTS, 4, number of CPU write ports (2..8)
FIFO_DEPTH, 4, entries per port FIFO (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_cpu  input  [NUM_WR_PORTS]  write request per port
wa_cpu  input  [NUM_WR_PORTS][SHIRINA_VSEH_BANOK]  write address
wd_cpu  input  [NUM_WR_PORTS][32]  write data
gnt_cpu  output  [NUM_WR_PORTS]  port may enqueue this cycle (FIFO not full)
err_cpu  output  [NUM_WR_PORTS]  one-cycle pulse: accepted address out of range
we_banki  output  [NUM_BANKS]  bank write enable
wa_banki  output  [NUM_BANKS][SHIRINA_BANKI]  in-bank write address
wd_banki  output  [NUM_BANKS][32]  bank write data
idle  output  1  all FIFOs empty and no bank write in flight

Behaviour:
- Single clock. rst is synchronous and active-high.
- Reset values:
  - we_banki=0, wa_banki=0, wd_banki=0, err_cpu=0.
  - FIFOs empty, so gnt_cpu all 1 and idle=1 in the cycle after reset.
  - All arbiter pointers = 0.
- Reset mid-operation discards every buffered and in-flight write. No stale write reaches a bank after rst is sampled.
- Handshake:
  - gnt_cpu[p] is a combinational function of FIFO occupancy only (= !full). It does not depend on req_cpu.
  - A write is accepted on the edge where req_cpu[p] && gnt_cpu[p].
  - No bypass: a full FIFO deasserts gnt even if it pops in the same cycle.
  - A port holds req/wa/wd stable until accepted.
- Decode:
  - bank = wa / SIZE_BANKI; local = wa % SIZE_BANKI.
  - If bank >= NUM_BANKS (e.g. address 96..127 with defaults), the write is accepted but not enqueued. err_cpu[p] pulses for one cycle, in the cycle after acceptance.
  - Decoded bank and local address are stored in the FIFO entry with the data.
- Arbitration, evaluated every cycle:
  - For each bank b, candidates are ports whose FIFO is non-empty and whose head targets b.
  - A per-bank round-robin pointer selects the first candidate at or after pointer[b]. Port 0 has highest priority after reset.
  - On a grant to port w, pointer[b] becomes (w+1) mod NUM_WR_PORTS. The pointer is unchanged when there is no grant.
  - A granted head pops on the same edge.
  - Each port pops at most one entry per cycle; each bank accepts at most one write per cycle.
- Output stage:
  - Winner's local address and data are registered into wa_banki[b]/wd_banki[b], with we_banki[b]=1 for exactly one cycle.
  - When there is no winner, we_banki[b]=0 and wa/wd hold their last value.
- Latency: write accepted at edge N, FIFO previously empty, bank uncontested -> we_banki high during cycle N+2. Sustained throughput is 1 write/cycle/bank.
- Ordering:
  - Per-port program order is preserved (head-only issue).
  - There is no ordering guarantee between ports.
  - Same-bank writes from different ports land in arbitration order.
- Simultaneous push and pop on one FIFO: occupancy unchanged, pointers both advance.
- Pointer wrap-around: read/write pointers carry one extra bit for full/empty discrimination.
- idle = all FIFOs empty && we_banki==0.

Test Plan:
- Port0 writes wa=37, wd=0xDEADBEEF at cycle 0, all else idle -> cycle 2: we_banki=3'b010, wa_banki[1]=5, wd_banki[1]=0xDEADBEEF. we_banki back to 0 at cycle 3; idle=1 at cycle 3.
- Ports 0,1,2 write bank 0 (wa=1,2,3; wd=0xA,0xB,0xC) at cycle 0 -> we_banki[0] at cycles 2,3,4 with wa=1,2,3 in that order. Repeat at cycle 10 with ports 0 and 2 -> port 0 (pointer=3 wraps to 0) at cycle 12, then port 2.
- Ports 0,1,2 write addresses 4, 36, 68 at cycle 0 -> cycle 2: we_banki=3'b111, wa_banki={4,4,4} for banks 2,1,0, each with its own data.
- Ports 0 and 1 each issue 8 back-to-back writes to bank 2 (wd = port*16+i) -> gnt_cpu[0] drops once the FIFO holds 4 entries. All 16 writes reach bank 2, alternating ports, per-port data ascending; no loss or duplication.
- Port 3 writes wa=100 at cycle 0 -> err_cpu[3]=1 in cycle 1 only; we_banki stays 0; idle=1 by cycle 2.
- Fill all four FIFOs to 3 entries with bank-1 writes, assert rst at cycle 3 -> from cycle 4: we_banki=0, gnt_cpu=4'hF, idle=1. None of the buffered data ever appears on wd_banki.
